// File: rtl/branch_pred_tracker.sv
// branch_pred_tracker
//
// Pipeline-side companion to a GShare predictor. Fetched branches look up the
// predictor combinationally and are queued in order ({pc, predicted}) in a
// small circular FIFO. When execute resolves the oldest branch, the entry is
// popped and one cycle later a training update is driven to the predictor.
// If the outcome disagrees with the prediction, a registered mispredict pulse
// is raised and the whole queue is flushed.
//
// Handshakes:
//   fetch:   a branch is accepted on a rising edge when fetch_valid=1 and
//            fetch_stall=0 (fetch_stall is the "not ready" of this port and is
//            based only on the registered count, so a same-cycle pop never
//            frees space). An accepted push is still dropped if the same edge
//            flushes on a mispredict.
//   resolve: resolve_valid always refers to the oldest in-flight branch and
//            is never back-pressured; with an empty queue it is ignored and
//            latches resolve_err.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   fetch_valid, fetch_pc           branch fetch request
//   fetch_taken, fetch_stall        predicted direction, queue-full stall
//   resolve_valid, resolve_taken    execute-stage outcome for the oldest entry
//   predictPC, predict, prediction  lookup port of the predictor
//   updatePC, update, reality       registered training port of the predictor
//   mispredict                      registered one-cycle flush pulse
//   occupancy                       registered queue count
//   resolve_err                     sticky resolve-while-empty flag
//   pred_count, miss_count          saturating statistics
//
// Queue state (EMPTY / PARTIAL / FULL) is fully described by occupancy.

module branch_pred_tracker #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  input  logic [15:0]      fetch_pc,
  output logic             fetch_taken,
  output logic             fetch_stall,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output logic [15:0]      predictPC,
  output logic             predict,
  input  logic             prediction,
  output logic [15:0]      updatePC,
  output logic             update,
  output logic             reality,
  output logic             mispredict,
  output logic [PTR_W:0]   occupancy,
  output logic             resolve_err,
  output logic [15:0]      pred_count,
  output logic [15:0]      miss_count
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [15:0]      pc_mem_q   [DEPTH];
  logic [DEPTH-1:0] pred_mem_q;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q;

  logic [15:0] update_pc_q;
  logic        update_q, reality_q, mispredict_q, resolve_err_q;
  logic [15:0] pred_count_q, miss_count_q;

  logic push, pop, miss;

  // Stall is evaluated on the registered count only.
  assign fetch_stall = (count_q == DEPTH_CNT);
  assign push        = fetch_valid & ~fetch_stall;
  assign pop         = resolve_valid & (count_q != '0);
  assign miss        = pop & (pred_mem_q[head_q] != resolve_taken);

  assign predictPC   = fetch_pc;
  assign predict     = push;
  assign fetch_taken = prediction;

  assign updatePC    = update_pc_q;
  assign update      = update_q;
  assign reality     = reality_q;
  assign mispredict  = mispredict_q;
  assign occupancy   = count_q;
  assign resolve_err = resolve_err_q;
  assign pred_count  = pred_count_q;
  assign miss_count  = miss_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      update_pc_q   <= '0;
      update_q      <= 1'b0;
      reality_q     <= 1'b0;
      mispredict_q  <= 1'b0;
      resolve_err_q <= 1'b0;
      pred_count_q  <= '0;
      miss_count_q  <= '0;
    end else begin
      update_q     <= pop;
      mispredict_q <= miss;
      if (pop) begin
        update_pc_q <= pc_mem_q[head_q];
        reality_q   <= resolve_taken;
      end
      if (resolve_valid && (count_q == '0)) begin
        resolve_err_q <= 1'b1;
      end

      if (miss) begin
        // Everything younger than the mispredicted branch is wrong-path,
        // including a push in this same cycle.
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        if (miss_count_q != 16'hFFFF) begin
          miss_count_q <= miss_count_q + 16'd1;
        end
      end else begin
        if (push) begin
          pc_mem_q[tail_q]   <= fetch_pc;
          pred_mem_q[tail_q] <= prediction;
          tail_q             <= tail_q + PTR_W'(1);
          if (pred_count_q != 16'hFFFF) begin
            pred_count_q <= pred_count_q + 16'd1;
          end
        end
        if (pop) begin
          head_q <= head_q + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + (PTR_W+1)'(1);
          2'b01:   count_q <= count_q - (PTR_W+1)'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_pred_tracker.sv
module tb_branch_pred_tracker;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int W     = 18; // {updatePC, reality, mispredict}

  logic             clk;
  logic             reset;
  logic             fetch_valid;
  logic [15:0]      fetch_pc;
  logic             fetch_taken;
  logic             fetch_stall;
  logic             resolve_valid;
  logic             resolve_taken;
  logic [15:0]      predictPC;
  logic             predict;
  logic             prediction;
  logic [15:0]      updatePC;
  logic             update;
  logic             reality;
  logic             mispredict;
  logic [PTR_W:0]   occupancy;
  logic             resolve_err;
  logic [15:0]      pred_count;
  logic [15:0]      miss_count;

  branch_pred_tracker #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_taken   (fetch_taken),
    .fetch_stall   (fetch_stall),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .predictPC     (predictPC),
    .predict       (predict),
    .prediction    (prediction),
    .updatePC      (updatePC),
    .update        (update),
    .reality       (reality),
    .mispredict    (mispredict),
    .occupancy     (occupancy),
    .resolve_err   (resolve_err),
    .pred_count    (pred_count),
    .miss_count    (miss_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [W-1:0]  exp_q[$];   // expected {updatePC, reality, mispredict}
  logic [16:0]   mdl_q[$];   // in-flight {pc, predicted}
  int unsigned   m_pred, m_miss;
  logic          m_err;
  logic          exp_upd;
  int            checks, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance the
  // model, then check registered outputs after the edge.
  task automatic step(input logic fv, input logic [15:0] pc, input logic pred,
                      input logic rv, input logic rt);
    logic        e_stall, e_push, mis;
    logic [16:0] e;
    logic [W-1:0] x;
    fetch_valid   = fv;
    fetch_pc      = pc;
    prediction    = pred;
    resolve_valid = rv;
    resolve_taken = rt;
    #1;
    e_stall = (mdl_q.size() == DEPTH);
    e_push  = fv && !e_stall;
    chk("fetch_stall", 32'(fetch_stall), 32'(e_stall));
    chk("predict",     32'(predict),     32'(e_push));
    chk("predictPC",   32'(predictPC),   32'(pc));
    chk("fetch_taken", 32'(fetch_taken), 32'(pred));

    mis     = 1'b0;
    exp_upd = 1'b0;
    if (rv && mdl_q.size() > 0) begin
      e       = mdl_q.pop_front();
      mis     = (e[0] != rt);
      exp_upd = 1'b1;
      exp_q.push_back({e[16:1], rt, mis});
    end else if (rv) begin
      m_err = 1'b1;
    end
    if (mis) begin
      mdl_q.delete();
      if (m_miss != 16'hFFFF) m_miss++;
    end else if (e_push) begin
      mdl_q.push_back({pc, pred});
      if (m_pred != 16'hFFFF) m_pred++;
    end

    @(posedge clk);
    #1;
    chk("update", 32'(update), 32'(exp_upd));
    if (exp_upd) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        x = exp_q.pop_front();
        chk("updatePC",   32'(updatePC),   32'(x[W-1:2]));
        chk("reality",    32'(reality),    32'(x[1]));
        chk("mispredict", 32'(mispredict), 32'(x[0]));
      end
    end else begin
      chk("mispredict_idle", 32'(mispredict), 32'd0);
    end
    chk("occupancy",   32'(occupancy),   32'(mdl_q.size()));
    chk("pred_count",  32'(pred_count),  m_pred);
    chk("miss_count",  32'(miss_count),  m_miss);
    chk("resolve_err", 32'(resolve_err), 32'(m_err));
  endtask

  // Reset with arbitrary same-cycle activity; everything must be discarded.
  task automatic do_reset(input logic fv, input logic rv);
    reset         = 1'b1;
    fetch_valid   = fv;
    fetch_pc      = 16'h0DEF;
    prediction    = 1'b1;
    resolve_valid = rv;
    resolve_taken = 1'b0;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    fetch_valid   = 1'b0;
    resolve_valid = 1'b0;
    mdl_q.delete();
    exp_q.delete();
    m_pred = 0;
    m_miss = 0;
    m_err  = 1'b0;
    chk("rst_occupancy",   32'(occupancy),   32'd0);
    chk("rst_update",      32'(update),      32'd0);
    chk("rst_mispredict",  32'(mispredict),  32'd0);
    chk("rst_updatePC",    32'(updatePC),    32'd0);
    chk("rst_reality",     32'(reality),     32'd0);
    chk("rst_pred_count",  32'(pred_count),  32'd0);
    chk("rst_miss_count",  32'(miss_count),  32'd0);
    chk("rst_resolve_err", 32'(resolve_err), 32'd0);
    chk("rst_fetch_stall", 32'(fetch_stall), 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        fv;
    logic [15:0] pc;
    logic        pred;
    logic        rv;
    logic        rt;
    logic [2:0]  e_occ;
    logic        e_upd;
    logic        e_mis;
    logic [15:0] e_upc;
    logic [15:0] e_pcnt;
    logic [15:0] e_mcnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    checks = 0;
    errors = 0;
    m_pred = 0;
    m_miss = 0;
    m_err  = 1'b0;
    reset  = 1'b1;
    fetch_valid = 1'b0; fetch_pc = '0; prediction = 1'b0;
    resolve_valid = 1'b0; resolve_taken = 1'b0;

    //          fv  pc        pd rv rt  occ upd mis upc       pcnt   mcnt
    vecs[0] = '{1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 16'h0000, 16'd1, 16'd0};
    vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 16'h00AA, 16'd1, 16'd0};
    vecs[2] = '{1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 16'h0000, 16'd2, 16'd0};
    vecs[3] = '{1'b1, 16'h00B0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 16'h0000, 16'd3, 16'd0};
    vecs[4] = '{1'b1, 16'h00C0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 16'h00AA, 16'd3, 16'd1};
    vecs[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000, 16'd3, 16'd1};

    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      step(vecs[i].fv, vecs[i].pc, vecs[i].pred, vecs[i].rv, vecs[i].rt);
      chk($sformatf("vec%0d_occ", i),  32'(occupancy),  32'(vecs[i].e_occ));
      chk($sformatf("vec%0d_upd", i),  32'(update),     32'(vecs[i].e_upd));
      chk($sformatf("vec%0d_mis", i),  32'(mispredict), 32'(vecs[i].e_mis));
      if (vecs[i].e_upd)
        chk($sformatf("vec%0d_upc", i), 32'(updatePC), 32'(vecs[i].e_upc));
      chk($sformatf("vec%0d_pcnt", i), 32'(pred_count), 32'(vecs[i].e_pcnt));
      chk($sformatf("vec%0d_mcnt", i), 32'(miss_count), 32'(vecs[i].e_mcnt));
    end

    // Fill to DEPTH, then a 5th fetch must stall and not be counted.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 16'h0100 + 16'(i), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    chk("full_stall", 32'(fetch_stall), 32'd1);
    step(1'b1, 16'h0104, 1'b1, 1'b0, 1'b0);
    chk("full_pred_count", 32'(pred_count), 32'd4);
    chk("full_occ", 32'(occupancy), 32'd4);

    // Correct resolve with simultaneous fetch while full: pop only.
    step(1'b1, 16'h0105, 1'b0, 1'b1, mdl_q[0][0]);
    chk("full_pop_occ", 32'(occupancy), 32'd3);
    chk("full_pop_upc", 32'(updatePC), 32'h0100);

    // Ten correct push/pop pairs walk the pointers around the ring.
    for (int i = 0; i < 10; i++)
      step(1'b1, 16'h0200 + 16'(i), 1'($urandom_range(0, 1)), 1'b1, mdl_q[0][0]);
    chk("wrap_occ", 32'(occupancy), 32'd3);

    // Drain with correct outcomes.
    while (mdl_q.size() > 0)
      step(1'b0, 16'h0000, 1'b0, 1'b1, mdl_q[0][0]);

    // Resolve on an empty queue: sticky error, no update.
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    chk("empty_err", 32'(resolve_err), 32'd1);
    repeat (3) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("err_sticky", 32'(resolve_err), 32'd1);

    // Random traffic, mixing correct and wrong outcomes.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 16'hFFFF)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)));

    // Reset mid-operation with three entries and a pending resolve.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'h0300 + 16'(i), 1'b1, 1'b0, 1'b0);
    do_reset(1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
